// File: rtl/phase_shift_ctl_pkg.sv
// Shared types and defaults for the DCM dynamic phase-shift sequencer.
package phase_shift_ctl_pkg;

  localparam int PHASE_W         = 9;
  localparam int PHASE_MAX_DEF   = 255;
  localparam int TIMEOUT_CYC_DEF = 1024;
  localparam int TO_W_DEF        = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2
  } ps_state_e;

  typedef logic signed [PHASE_W-1:0] phase_t;

  // Saturate a requested phase into the legal symmetric range.
  function automatic phase_t clamp_phase(input phase_t p, input int pmax);
    if (int'(p) > pmax)  return phase_t'(pmax);
    if (int'(p) < -pmax) return phase_t'(-pmax);
    return p;
  endfunction

endpackage

// File: rtl/phase_shift_ctl_if.sv
// Register-block and DCM phase-shift port bundle for phase_shift_ctl.
interface phase_shift_ctl_if;
  import phase_shift_ctl_pkg::*;

  logic [PHASE_W-1:0] phase_i;
  logic               phase_ld_i;
  logic               dcm_psdone_i;
  logic               dcm_locked_i;
  logic               dcm_psen_o;
  logic               dcm_psincdec_o;
  logic [PHASE_W-1:0] phase_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;

  // master: register block + DCM side; slave: the sequencer
  modport master (
    output phase_i, phase_ld_i, dcm_psdone_i, dcm_locked_i,
    input  dcm_psen_o, dcm_psincdec_o, phase_o, busy_o, done_o, err_o
  );

  modport slave (
    input  phase_i, phase_ld_i, dcm_psdone_i, dcm_locked_i,
    output dcm_psen_o, dcm_psincdec_o, phase_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/phase_step_timer.sv
// Loadable saturating up-counter with terminal-count flag (psdone timeout).
module phase_step_timer #(
  parameter int W    = 10,
  parameter int TERM = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [W-1:0] TERM_C = W'(TERM);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)      cnt <= '0;
    else if (en && !tc)    cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == TERM_C);
endmodule

// File: rtl/phase_shift_ctl.sv
// Steps the DCM phase-shift port one PSEN at a time toward a host target phase,
// tracking the applied phase and reporting done / error.
module phase_shift_ctl
  import phase_shift_ctl_pkg::*;
#(
  parameter int PHASE_MAX   = PHASE_MAX_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TO_W        = TO_W_DEF
) (
  input  logic clk,
  input  logic reset_i,
  phase_shift_ctl_if.slave ps
);

  ps_state_e state;
  phase_t    target;
  phase_t    phase_q;
  phase_t    phase_nxt;
  logic      dir_q;
  logic      done_q;
  logic      err_q;
  logic      to_tc;
  logic      locked;
  logic      pending;
  logic      up_req;

  assign locked    = ps.dcm_locked_i;
  assign up_req    = (target > phase_q);
  assign pending   = (target != phase_q) && !err_q && locked;
  assign phase_nxt = dir_q ? phase_q + phase_t'(1) : phase_q - phase_t'(1);

  phase_step_timer #(
    .W    (TO_W),
    .TERM (TIMEOUT_CYC - 1)
  ) u_timer (
    .clk   (clk),
    .reset (reset_i),
    .clr   (state == STEP),
    .en    (state == WAIT),
    .tc    (to_tc)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state   <= IDLE;
      target  <= '0;
      phase_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // A new load clears status; error sets below are later and take priority.
      if (ps.phase_ld_i) begin
        target <= clamp_phase(phase_t'(ps.phase_i), PHASE_MAX);
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end

      if (!locked) begin
        // DCM drops its accumulated shift on relock.
        phase_q <= '0;
        state   <= IDLE;
        if (state != IDLE) err_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (target == phase_q) begin
              if (!ps.phase_ld_i) done_q <= 1'b1;
            end else if (!err_q) begin
              state <= STEP;
            end
          end
          STEP: begin
            dir_q <= up_req;
            state <= WAIT;
          end
          WAIT: begin
            if (ps.dcm_psdone_i) begin
              phase_q <= phase_nxt;
              state   <= IDLE;
              if (!ps.phase_ld_i && phase_nxt == target) done_q <= 1'b1;
            end else if (to_tc) begin
              err_q <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Gated so PSEN drops in the very cycle reset or lock loss is seen.
  assign ps.dcm_psen_o     = (state == STEP) && locked && !reset_i;
  assign ps.dcm_psincdec_o = (state == STEP) && locked && !reset_i && up_req;
  assign ps.phase_o        = phase_q;
  assign ps.busy_o         = (state != IDLE) || pending;
  assign ps.done_o         = done_q;
  assign ps.err_o          = err_q;

endmodule

// File: tb/tb_phase_shift_ctl.sv
// Self-checking bench for phase_shift_ctl with a behavioural DCM phase-shift model.
module tb_phase_shift_ctl;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  phase_shift_ctl_if bus();

  phase_shift_ctl dut (
    .clk     (clk),
    .reset_i (reset_i),
    .ps      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // DCM model state
  int lat = 3;
  int cd = 0;
  int withhold_at = 0;
  int spur = 0;
  int n_psen = 0, n_inc = 0, n_dec = 0, n_bad = 0, n_long = 0;
  logic prev_psen = 1'b0;
  int ref_phase = 0;

  always @(negedge clk) begin
    bus.dcm_psdone_i = (spur != 0);
    spur = 0;
    if (reset_i || !bus.dcm_locked_i) cd = 0;
    else if (cd > 0) begin
      cd--;
      if (cd == 0) bus.dcm_psdone_i = 1'b1;
    end
    if (bus.dcm_psen_o) begin
      n_psen++;
      if (bus.dcm_psincdec_o) n_inc++; else n_dec++;
      if (!bus.dcm_locked_i) n_bad++;
      if (prev_psen) n_long++;
      if (n_psen != withhold_at) cd = lat;
    end
    prev_psen = bus.dcm_psen_o;
  end

  function automatic int clampi(input int v);
    if (v > 255)  return 255;
    if (v < -255) return -255;
    return v;
  endfunction

  function automatic int cur_phase();
    return int'($signed(bus.phase_o));
  endfunction

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clr_counts();
    n_psen = 0; n_inc = 0; n_dec = 0; n_bad = 0;
  endtask

  task automatic load(input int v);
    @(negedge clk);
    bus.phase_i    = 9'(v);
    bus.phase_ld_i = 1'b1;
    @(negedge clk);
    bus.phase_ld_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    tick(3);
    reset_i = 1'b0;
    ref_phase = 0;
  endtask

  task automatic settle(input string name, input int budget);
    int c = 0;
    tick(1);
    while (bus.busy_o && c < budget) begin tick(1); c++; end
    n_cmp++;
    if (c >= budget) begin
      $display("FAIL %s settle: busy still %0b after %0d cycles, required 0", name, bus.busy_o, budget);
      n_err++;
    end
  endtask

  task automatic wait_psen(input string name, input int want, input int budget);
    int c = 0;
    while (n_psen < want && c < budget) begin tick(1); c++; end
    n_cmp++;
    if (n_psen < want) begin
      $display("FAIL %s wait_psen: got %0d pulses, required %0d", name, n_psen, want);
      n_err++;
    end
  endtask

  task automatic test_reset();
    bus.phase_i = '0; bus.phase_ld_i = 1'b0; bus.dcm_locked_i = 1'b0;
    reset_i = 1'b1;
    tick(3);
    n_cmp++;
    if ({bus.dcm_psen_o, bus.dcm_psincdec_o, bus.busy_o, bus.done_o, bus.err_o, bus.phase_o} !== 14'h0) begin
      $display("FAIL reset_state: got %b, required all zero",
               {bus.dcm_psen_o, bus.dcm_psincdec_o, bus.busy_o, bus.done_o, bus.err_o, bus.phase_o});
      n_err++;
    end
    bus.dcm_locked_i = 1'b1;
    reset_i = 1'b0;
    tick(2);
  endtask

  task automatic test_seq(input string name, input int v, input int budget);
    int exp = clampi(v);
    int ei = (exp > ref_phase) ? exp - ref_phase : 0;
    int ed = (exp < ref_phase) ? ref_phase - exp : 0;
    clr_counts();
    load(v);
    settle(name, budget);
    n_cmp++;
    if (cur_phase() !== exp) begin
      $display("FAIL %s phase: got %0d, required %0d", name, cur_phase(), exp); n_err++;
    end
    n_cmp++;
    if (n_inc !== ei || n_dec !== ed) begin
      $display("FAIL %s steps: got inc=%0d dec=%0d, required inc=%0d dec=%0d", name, n_inc, n_dec, ei, ed);
      n_err++;
    end
    n_cmp++;
    if ({bus.done_o, bus.err_o, bus.busy_o} !== 3'b100) begin
      $display("FAIL %s status: got done/err/busy=%b, required 100", name, {bus.done_o, bus.err_o, bus.busy_o});
      n_err++;
    end
    ref_phase = exp;
  endtask

  task automatic test_equal();
    clr_counts();
    load(ref_phase);
    n_cmp++;
    if (bus.done_o !== 1'b0) begin
      $display("FAIL equal_clear: done got %0b, required 0", bus.done_o); n_err++;
    end
    tick(1);
    n_cmp++;
    if (bus.done_o !== 1'b1) begin
      $display("FAIL equal_done: done got %0b, required 1", bus.done_o); n_err++;
    end
    tick(10);
    n_cmp++;
    if (n_psen !== 0) begin
      $display("FAIL equal_nopsen: got %0d pulses, required 0", n_psen); n_err++;
    end
  endtask

  task automatic test_reversal();
    do_reset();
    clr_counts();
    load(100);
    wait_psen("reversal", 11, 200);
    tick(1);
    load(2);
    settle("reversal", 500);
    n_cmp++;
    if (n_inc !== 11 || n_dec !== 9 || cur_phase() !== 2) begin
      $display("FAIL reversal: got inc=%0d dec=%0d phase=%0d, required inc=11 dec=9 phase=2", n_inc, n_dec, cur_phase());
      n_err++;
    end
    ref_phase = 2;
  endtask

  task automatic test_timeout();
    do_reset();
    clr_counts();
    withhold_at = 3;
    load(7);
    settle("timeout", 3000);
    n_cmp++;
    if (bus.err_o !== 1'b1 || cur_phase() !== 2 || bus.done_o !== 1'b0) begin
      $display("FAIL timeout_err: got err=%0b phase=%0d done=%0b, required err=1 phase=2 done=0",
               bus.err_o, cur_phase(), bus.done_o);
      n_err++;
    end
    tick(50);
    n_cmp++;
    if (n_psen !== 3) begin
      $display("FAIL timeout_suppress: got %0d pulses, required 3", n_psen); n_err++;
    end
    withhold_at = 0;
    load(2);
    n_cmp++;
    if (bus.err_o !== 1'b0) begin
      $display("FAIL timeout_clear: err got %0b, required 0", bus.err_o); n_err++;
    end
    tick(1);
    n_cmp++;
    if (bus.done_o !== 1'b1 || n_psen !== 3) begin
      $display("FAIL timeout_reload: got done=%0b pulses=%0d, required done=1 pulses=3", bus.done_o, n_psen);
      n_err++;
    end
    ref_phase = 2;
  endtask

  task automatic test_lock_loss();
    do_reset();
    clr_counts();
    load(50);
    wait_psen("lock", 4, 200);
    tick(1);
    bus.dcm_locked_i = 1'b0;
    tick(1);
    n_cmp++;
    if (cur_phase() !== 0 || bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      $display("FAIL lock_drop: got phase=%0d err=%0b busy=%0b, required 0 1 0", cur_phase(), bus.err_o, bus.busy_o);
      n_err++;
    end
    tick(20);
    bus.dcm_locked_i = 1'b1;
    tick(20);
    n_cmp++;
    if (n_psen !== 4 || n_bad !== 0) begin
      $display("FAIL lock_nopsen: got pulses=%0d unlocked=%0d, required 4 0", n_psen, n_bad); n_err++;
    end
    ref_phase = 0;
    test_seq("lock_reload", 50, 1000);
  endtask

  task automatic test_spurious();
    int p0 = n_psen;
    spur = 1;
    tick(4);
    n_cmp++;
    if (cur_phase() !== ref_phase || n_psen !== p0) begin
      $display("FAIL spurious: got phase=%0d pulses=%0d, required %0d %0d", cur_phase(), n_psen, ref_phase, p0);
      n_err++;
    end
  endtask

  task automatic test_reset_mid();
    clr_counts();
    load(-20);
    wait_psen("reset_mid", 2, 200);
    reset_i = 1'b1;
    #1;
    n_cmp++;
    if (bus.dcm_psen_o !== 1'b0) begin
      $display("FAIL reset_mid_psen: got %0b, required 0", bus.dcm_psen_o); n_err++;
    end
    tick(1);
    n_cmp++;
    if (cur_phase() !== 0 || bus.busy_o !== 1'b0) begin
      $display("FAIL reset_mid_state: got phase=%0d busy=%0b, required 0 0", cur_phase(), bus.busy_o); n_err++;
    end
    reset_i = 1'b0;
    ref_phase = 0;
    tick(2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int v;
      lat = $urandom_range(1, 5);
      v = (k == 3) ? 255 : int'($urandom_range(0, 200)) - 100;
      test_seq("random", v, 6000);
    end
    lat = 3;
    n_cmp++;
    if (n_long !== 0) begin
      $display("FAIL psen_width: got %0d multi-cycle pulses, required 0", n_long); n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_seq("up5", 5, 200);
    test_seq("down_m3", -3, 300);
    do_reset();
    test_seq("clamp", -256, 3000);
    test_equal();
    test_reversal();
    test_timeout();
    test_lock_loss();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_shift_ctl.md
Name: phase_shift_ctl

Overview:
Sequences the DCM dynamic phase-shift port so the host can request an absolute ADC sample-clock phase.
- The register block supplies a signed 9-bit target and a load strobe.
- This block issues single PSEN/PSINCDEC steps to the DCM, waits for PSDONE after each one, and tracks the phase actually applied.
- It reports done/error status back to the register block.
- Sits between the register interface and the ADC clock DCM, in the clk domain.

Parameters:
PHASE_MAX, 255, largest legal positive phase in DCM steps; target clamped to ±PHASE_MAX.
TIMEOUT_CYC, 1024, cycles to wait for dcm_psdone_i after a step before declaring error.
TO_W, 10, width of the timeout counter (TIMEOUT_CYC must be ≤ 2^TO_W).

Ports:
clk  in  1  system clock; also drives DCM PSCLK.
reset_i  in  1  synchronous, active-high reset.
phase_i  in  9  target phase, two's complement (-256..255).
phase_ld_i  in  1  one-cycle strobe: latch phase_i as the new target.
dcm_psdone_i  in  1  DCM step-complete pulse.
dcm_locked_i  in  1  DCM lock status.
dcm_psen_o  out  1  DCM phase-shift enable, one-cycle pulse per step.
dcm_psincdec_o  out  1  1 = increment, 0 = decrement; valid while dcm_psen_o = 1.
phase_o  out  9  phase currently applied (signed).
busy_o  out  1  a shift sequence is in progress.
done_o  out  1  sticky; set when phase_o == target, cleared by phase_ld_i.
err_o  out  1  sticky; set on timeout or lock loss, cleared by phase_ld_i.

Behaviour:
Reset values:
- All outputs 0; state IDLE; target 0; pending flag 0.

Target latch:
- phase_ld_i latches phase_i into target, clamped to [-PHASE_MAX, +PHASE_MAX].
- -256 becomes -255 with the default parameter.
- Clears done_o and err_o.

States:
- IDLE: when target != phase_o and dcm_locked_i = 1, go to STEP; otherwise stay. done_o is set whenever IDLE is entered with target == phase_o.
- STEP: assert dcm_psen_o for exactly 1 cycle; dcm_psincdec_o = (target > phase_o, signed compare); clear the timeout counter; go to WAIT.
- WAIT: dcm_psen_o = 0.
  - On dcm_psdone_i: phase_o ±1 according to the direction issued, then go to IDLE.
  - The next step can issue 2 cycles after psdone (WAIT→IDLE→STEP).
  - If the counter reaches TIMEOUT_CYC-1 without psdone: set err_o, do not update phase_o, go to IDLE, and suppress further steps until the next phase_ld_i.
- busy_o = 1 in STEP and WAIT, and in IDLE whenever a step is pending (target != phase_o, no error, locked).

Boundary conditions:
- phase_ld_i during WAIT: the new target latches immediately. The outstanding step still completes and phase_o is updated for it. Direction is re-evaluated on the next STEP, so reversal costs at most one extra step.
- phase_ld_i with target == phase_o: done_o sets the next cycle; no PSEN is issued.
- dcm_psdone_i in IDLE or STEP (spurious): ignored, phase_o unchanged.
- dcm_locked_i falling in any state:
  - phase_o := 0 (the DCM resets its shift on relock).
  - If the state is not IDLE, set err_o.
  - Go to IDLE.
  - No steps are issued while unlocked.
  - After relock, stepping toward target resumes automatically only if err_o = 0.
- Reset mid-sequence: immediate return to IDLE, phase_o = 0, PSEN deasserted in the same cycle it is sampled.
- Timeout counter is TO_W bits and never wraps; it saturates at the terminal count.

Decomposition:
- Shared package: state encoding (IDLE, STEP, WAIT), PHASE_W = 9, default PHASE_MAX, default TIMEOUT_CYC.
- Sub-module phase_step_timer: a loadable saturating counter with a terminal-count flag, reused for the psdone timeout.
- The FSM and the phase accumulator stay in phase_shift_ctl.

Test Plan:
- Reset, then phase_ld_i with phase_i = 5 and the DCM model returning psdone 3 cycles after PSEN -> exactly 5 PSEN pulses with psincdec = 1; phase_o = 5; done_o = 1; busy_o = 0.
- From phase_o = 5, load -3 -> 8 PSEN pulses with psincdec = 0; phase_o = -3 (9'h1FD); done_o = 1.
- Load -256 -> clamped; phase_o ends at -255 after 255 decrements from 0.
- Load 100; after 10 steps, load 2 while in WAIT -> the step in flight completes (phase_o = 11), then 9 decrements; final phase_o = 2.
- DCM model withholds psdone on the 3rd step -> err_o = 1 after TIMEOUT_CYC cycles; phase_o = 2; no further PSEN until the next load; load 2 clears err_o and sets done_o.
- Drop dcm_locked_i during step 4 of a target-50 sequence -> phase_o = 0, err_o = 1, no PSEN while unlocked; relock alone gives no PSEN; a reload of 50 restarts the sequence and reaches 50.
